decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl_pkg.sv | 49 ++++
 rtl/decode_ctrl_if.sv | 33 +++
 rtl/decode_ctrl_instr_decode.sv | 90 +++++++++
 rtl/decode_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_decode_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared constants and types for the RV32I decode/control slice:
// opcode and funct field values, ALU control codes, operand-select codes,
// the controller state enumeration and the instruction class enumeration.
package decode_ctrl_pkg;

    // Major opcodes handled by this block
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Second-operand select
    localparam logic [1:0] MUX_RV2 = 2'd0;
    localparam logic [1:0] MUX_IMM = 2'd1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_RTYPE  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } instr_class_t;

endpackage

// File: rtl/decode_ctrl_if.sv
// Instruction handshake plus register-file, ALU and data-memory side signals
// of the decode/control block. master = upstream/environment, slave = block.
interface decode_ctrl_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  control;
    logic [1:0]  mux;
    logic        regWrite;
    logic [31:0] data;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;
    logic        done;
    logic        illegal;
    logic        branch_taken;

    modport master (
        output instr_valid, instr, alu_result, mem_rdata,
        input  instr_ready, rs1, rs2, rd, control, mux, regWrite, data,
               mem_read, mem_write, done, illegal, branch_taken
    );

    modport slave (
        input  instr_valid, instr, alu_result, mem_rdata,
        output instr_ready, rs1, rs2, rd, control, mux, regWrite, data,
               mem_read, mem_write, done, illegal, branch_taken
    );
endinterface

// File: rtl/decode_ctrl_instr_decode.sv
// Purely combinational RV32I subset decoder: register indices, ALU control,
// operand select, instruction class and a legal flag for one instruction word.
module instr_decode
    import decode_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output logic [4:0]   rs1,
    output logic [4:0]   rs2,
    output logic [4:0]   rd,
    output logic [3:0]   control,
    output logic [1:0]   mux,
    output instr_class_t instr_class,
    output logic         legal
);

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [6:0] funct7_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];

    // Classify the opcode/funct combination; anything unmatched stays illegal
    always_comb begin
        control     = ALU_AND;
        mux         = MUX_RV2;
        instr_class = CLS_NONE;
        legal       = 1'b0;
        case (opcode_s)
            OP_RTYPE: begin
                if (funct3_s == F3_ADD_SUB && funct7_s == F7_BASE) begin
                    control     = ALU_ADD;
                    instr_class = CLS_RTYPE;
                    legal       = 1'b1;
                end else if (funct3_s == F3_ADD_SUB && funct7_s == F7_ALT) begin
                    control     = ALU_SUB;
                    instr_class = CLS_RTYPE;
                    legal       = 1'b1;
                end else if (funct3_s == F3_OR && funct7_s == F7_BASE) begin
                    control     = ALU_OR;
                    instr_class = CLS_RTYPE;
                    legal       = 1'b1;
                end else if (funct3_s == F3_AND && funct7_s == F7_BASE) begin
                    control     = ALU_AND;
                    instr_class = CLS_RTYPE;
                    legal       = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_LOAD: begin
                if (funct3_s == F3_WORD) begin
                    control     = ALU_ADD;
                    mux         = MUX_IMM;
                    instr_class = CLS_LOAD;
                    legal       = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_STORE: begin
                if (funct3_s == F3_WORD) begin
                    control     = ALU_ADD;
                    mux         = MUX_IMM;
                    instr_class = CLS_STORE;
                    legal       = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OP_BRANCH: begin
                if (funct3_s == F3_BEQ) begin
                    control     = ALU_SUB;
                    instr_class = CLS_BRANCH;
                    legal       = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Multi-cycle decode/control FSM: accepts one instruction at a time in IDLE,
// walks READ -> EXEC -> (MEM x MEM_WAIT) -> WB, and drives register-file and
// data-memory strobes. All outputs are registered, so each strobe appears the
// cycle after the state that produces it.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
)(
    input  logic         clk,
    input  logic         reset,
    decode_ctrl_if.slave bus
);

    state_t       state_r;
    state_t       next_state_s;

    logic [4:0]   dec_rs1_s;
    logic [4:0]   dec_rs2_s;
    logic [4:0]   dec_rd_s;
    logic [3:0]   dec_control_s;
    logic [1:0]   dec_mux_s;
    instr_class_t dec_class_s;
    logic         dec_legal_s;

    logic         accept_s;
    logic         mem_last_s;
    logic         is_mem_op_s;

    logic         instr_ready_r;
    logic [4:0]   rs1_r;
    logic [4:0]   rs2_r;
    logic [4:0]   rd_r;
    logic [3:0]   control_r;
    logic [1:0]   mux_r;
    instr_class_t class_r;
    logic [3:0]   mem_cnt_r;
    logic [31:0]  mem_data_r;
    logic         regwrite_r;
    logic [31:0]  data_r;
    logic         mem_read_r;
    logic         mem_write_r;
    logic         done_r;
    logic         illegal_r;
    logic         branch_taken_r;

    instr_decode u_decode (
        .instr       (bus.instr),
        .rs1         (dec_rs1_s),
        .rs2         (dec_rs2_s),
        .rd          (dec_rd_s),
        .control     (dec_control_s),
        .mux         (dec_mux_s),
        .instr_class (dec_class_s),
        .legal       (dec_legal_s)
    );

    assign accept_s    = bus.instr_valid && instr_ready_r;
    assign mem_last_s  = (mem_cnt_r == 4'(MEM_WAIT - 1));
    assign is_mem_op_s = (class_r == CLS_LOAD) || (class_r == CLS_STORE);

    // Next-state selection; illegal words are consumed without leaving IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && dec_legal_s) begin
                    next_state_s = ST_READ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: next_state_s = ST_EXEC;
            ST_EXEC: begin
                if (is_mem_op_s) begin
                    next_state_s = ST_MEM;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_last_s) begin
                    next_state_s = ST_WB;
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register; ready is a registered copy of "next state is IDLE"
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            instr_ready_r <= 1'b1;
        end else begin
            state_r       <= next_state_s;
            instr_ready_r <= (next_state_s == ST_IDLE);
        end
    end

    // Capture decoded fields on acceptance and hold them until the next one
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_r     <= 5'd0;
            rs2_r     <= 5'd0;
            rd_r      <= 5'd0;
            control_r <= 4'd0;
            mux_r     <= 2'd0;
            class_r   <= CLS_NONE;
        end else if (accept_s) begin
            rs1_r     <= dec_rs1_s;
            rs2_r     <= dec_rs2_s;
            rd_r      <= dec_rd_s;
            control_r <= dec_control_s;
            mux_r     <= dec_mux_s;
            class_r   <= dec_class_s;
        end
    end

    // MEM dwell counter; load data is sampled on the final MEM cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_cnt_r  <= 4'd0;
            mem_data_r <= 32'd0;
        end else if (state_r == ST_MEM) begin
            mem_cnt_r <= mem_cnt_r + 4'd1;
            if (mem_last_s) begin
                mem_data_r <= bus.mem_rdata;
            end
        end else begin
            mem_cnt_r <= 4'd0;
        end
    end

    // Registered strobes and write-back data derived from the current state
    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_r     <= 1'b0;
            data_r         <= 32'd0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            done_r         <= 1'b0;
            illegal_r      <= 1'b0;
            branch_taken_r <= 1'b0;
        end else begin
            regwrite_r     <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            done_r         <= 1'b0;
            illegal_r      <= 1'b0;
            branch_taken_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && !dec_legal_s) begin
                        illegal_r <= 1'b1;
                        done_r    <= 1'b1;
                    end
                end
                ST_MEM: begin
                    mem_read_r  <= (class_r == CLS_LOAD);
                    mem_write_r <= (class_r == CLS_STORE);
                end
                ST_WB: begin
                    done_r         <= 1'b1;
                    branch_taken_r <= (class_r == CLS_BRANCH) && (bus.alu_result == 32'd0);
                    if (((class_r == CLS_RTYPE) || (class_r == CLS_LOAD)) && (rd_r != 5'd0)) begin
                        regwrite_r <= 1'b1;
                        data_r     <= (class_r == CLS_LOAD) ? mem_data_r : bus.alu_result;
                    end
                end
                default: begin
                    regwrite_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instr_ready  = instr_ready_r;
    assign bus.rs1          = rs1_r;
    assign bus.rs2          = rs2_r;
    assign bus.rd           = rd_r;
    assign bus.control      = control_r;
    assign bus.mux          = mux_r;
    assign bus.regWrite     = regwrite_r;
    assign bus.data         = data_r;
    assign bus.mem_read     = mem_read_r;
    assign bus.mem_write    = mem_write_r;
    assign bus.done         = done_r;
    assign bus.illegal      = illegal_r;
    assign bus.branch_taken = branch_taken_r;

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl (MEM_WAIT=2). Each instruction's expected
// outcome is queued when it is driven and popped when the block retires it.
module tb_decode_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    decode_ctrl_if bus();

    decode_ctrl #(.MEM_WAIT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic        ill;
        logic        chk;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic [1:0]  mux;
        int          nrd;
        int          nwr;
        int          nrw;
        logic [31:0] data;
        logic        br;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic exp_t mk(input int lat, input logic ill, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [3:0] ctl, input logic [1:0] mux,
                                input int nrd, input int nwr, input int nrw,
                                input logic [31:0] data, input logic br);
        exp_t e;
        e.lat = lat; e.ill = ill; e.chk = !ill;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ctl = ctl; e.mux = mux;
        e.nrd = nrd; e.nwr = nwr; e.nrw = nrw; e.data = data; e.br = br;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one instruction, keep a different word valid while busy (must be
    // ignored), wait for done within a bound, then compare against the queue.
    task automatic run(input string name, input logic [31:0] w,
                       input logic [31:0] alu, input logic [31:0] mrd);
        exp_t        e;
        int          lat = 0;
        int          nrd = 0;
        int          nwr = 0;
        int          nrw = 0;
        logic [31:0] wdata = 32'd0;
        logic        seen = 1'b0;
        bus.instr       = w;
        bus.alu_result  = alu;
        bus.mem_rdata   = mrd;
        bus.instr_valid = 1'b1;
        check({name, ".ready_in"}, 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        bus.instr = 32'h40000033;
        for (int c = 0; c <= 30; c++) begin
            if (bus.mem_read)  nrd++;
            if (bus.mem_write) nwr++;
            if (bus.regWrite) begin
                nrw++;
                wdata = bus.data;
            end
            if (bus.done) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.instr_valid = 1'b0;
        e = sb.pop_front();
        check({name, ".done_seen"}, 32'(seen), 32'd1);
        check({name, ".latency"}, 32'(lat), 32'(e.lat));
        check({name, ".illegal"}, 32'(bus.illegal), 32'(e.ill));
        check({name, ".mem_read_cycles"}, 32'(nrd), 32'(e.nrd));
        check({name, ".mem_write_cycles"}, 32'(nwr), 32'(e.nwr));
        check({name, ".regwrite_pulses"}, 32'(nrw), 32'(e.nrw));
        check({name, ".branch_taken"}, 32'(bus.branch_taken), 32'(e.br));
        check({name, ".ready_at_done"}, 32'(bus.instr_ready), 32'd1);
        if (e.chk) begin
            check({name, ".rs1"}, 32'(bus.rs1), 32'(e.rs1));
            check({name, ".rs2"}, 32'(bus.rs2), 32'(e.rs2));
            check({name, ".rd"}, 32'(bus.rd), 32'(e.rd));
            check({name, ".control"}, 32'(bus.control), 32'(e.ctl));
            check({name, ".mux"}, 32'(bus.mux), 32'(e.mux));
        end
        if (e.nrw != 0) begin
            check({name, ".data"}, wdata, e.data);
        end
        @(posedge clk); #1;
        check({name, ".done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.alu_result  = 32'd0;
        bus.mem_rdata   = 32'd0;

        // Reset state with a request pending: nothing may be accepted
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h002081B3;
        repeat (3) @(posedge clk);
        #1;
        check("rst.done", 32'(bus.done), 32'd0);
        check("rst.regwrite", 32'(bus.regWrite), 32'd0);
        check("rst.data", bus.data, 32'd0);
        check("rst.control", 32'(bus.control), 32'd0);
        check("rst.rs1", 32'(bus.rs1), 32'd0);
        check("rst.mem_read", 32'(bus.mem_read), 32'd0);
        check("rst.mem_write", 32'(bus.mem_write), 32'd0);
        check("rst.illegal", 32'(bus.illegal), 32'd0);
        check("rst.branch", 32'(bus.branch_taken), 32'd0);
        bus.instr_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst.ready_after", 32'(bus.instr_ready), 32'd1);

        //           lat ill rs1   rs2   rd    ctl      mux   rd wr rw data           br
        sb.push_back(mk(3, 0, 5'd1, 5'd2, 5'd3, 4'b0010, 2'd0, 0, 0, 1, 32'h0000000A, 0));
        run("add", 32'h002081B3, 32'h0000000A, 32'h0);

        sb.push_back(mk(3, 0, 5'd1, 5'd2, 5'd3, 4'b0110, 2'd0, 0, 0, 1, 32'h00000005, 0));
        run("sub", 32'h402081B3, 32'h00000005, 32'h0);

        sb.push_back(mk(0, 1, 5'd0, 5'd0, 5'd0, 4'b0000, 2'd0, 0, 0, 0, 32'h0, 0));
        run("illegal_ones", 32'hFFFFFFFF, 32'h0, 32'h0);

        sb.push_back(mk(3, 0, 5'd1, 5'd2, 5'd3, 4'b0001, 2'd0, 0, 0, 1, 32'h12345678, 0));
        run("or", 32'h0020E1B3, 32'h12345678, 32'h0);

        sb.push_back(mk(3, 0, 5'd1, 5'd2, 5'd3, 4'b0000, 2'd0, 0, 0, 1, 32'hCAFE0000, 0));
        run("and", 32'h0020F1B3, 32'hCAFE0000, 32'h0);

        sb.push_back(mk(5, 0, 5'd1, 5'd0, 5'd5, 4'b0010, 2'd1, 2, 0, 1, 32'hDEADBEEF, 0));
        run("lw", 32'h0000A283, 32'h00000100, 32'hDEADBEEF);

        sb.push_back(mk(5, 0, 5'd1, 5'd2, 5'd0, 4'b0010, 2'd1, 0, 2, 0, 32'h0, 0));
        run("sw", 32'h0020A023, 32'h00000100, 32'h0);

        sb.push_back(mk(3, 0, 5'd1, 5'd2, 5'd0, 4'b0110, 2'd0, 0, 0, 0, 32'h0, 1));
        run("beq_taken", 32'h00208063, 32'h00000000, 32'h0);

        sb.push_back(mk(3, 0, 5'd1, 5'd2, 5'd0, 4'b0110, 2'd0, 0, 0, 0, 32'h0, 0));
        run("beq_not_taken", 32'h00208063, 32'h00000005, 32'h0);

        sb.push_back(mk(3, 0, 5'd1, 5'd2, 5'd0, 4'b0010, 2'd0, 0, 0, 0, 32'h0, 0));
        run("add_x0", 32'h00208033, 32'h00000077, 32'h0);

        sb.push_back(mk(0, 1, 5'd0, 5'd0, 5'd0, 4'b0000, 2'd0, 0, 0, 0, 32'h0, 0));
        run("illegal_funct7", 32'h202081B3, 32'h0, 32'h0);

        // Reset during EXEC of an add, with a sub held valid throughout
        bus.instr       = 32'h002081B3;
        bus.alu_result  = 32'h00000009;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset     = 1'b1;
        bus.instr = 32'h402081B3;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("midrst.done", 32'(bus.done), 32'd0);
            check("midrst.regwrite", 32'(bus.regWrite), 32'd0);
            check("midrst.mem_read", 32'(bus.mem_read), 32'd0);
            check("midrst.control", 32'(bus.control), 32'd0);
            check("midrst.rs1", 32'(bus.rs1), 32'd0);
        end
        reset = 1'b0;
        check("midrst.ready", 32'(bus.instr_ready), 32'd1);

        sb.push_back(mk(3, 0, 5'd1, 5'd2, 5'd3, 4'b0110, 2'd0, 0, 0, 1, 32'h00000009, 0));
        run("sub_after_reset", 32'h402081B3, 32'h00000009, 32'h0);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
